// File: rtl/inst_encoder.sv
// Packs decoded RV32I fields plus a signed immediate into an instruction word; 2-cycle latency.
// Valid/ready on both sides; a stalled output freezes stage 2 and in_ready drops once stage 1 is also full.
module inst_encoder #(
   parameter int          ERR_CNT_W = 8,
   parameter logic [31:0] NOP_INST  = 32'h00000013
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic                 out_err,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R} fmt_t;

   logic                 r_s1_valid;
   fmt_t                 r_s1_fmt;
   logic                 r_s1_err;
   logic [6:0]           r_s1_op;
   logic [4:0]           r_s1_rd;
   logic [4:0]           r_s1_rs1;
   logic [4:0]           r_s1_rs2;
   logic [2:0]           r_s1_f3;
   logic [6:0]           r_s1_f7;
   logic [31:0]          r_s1_imm;
   logic                 r_s2_valid;
   logic [31:0]          r_out_inst;
   logic                 r_out_err;
   logic [ERR_CNT_W-1:0] r_err_count;

   fmt_t        w_fmt;
   logic        w_op_ok;
   logic        w_imm_ok;
   logic        w_fits12;
   logic        w_fits13;
   logic        w_fits21;
   logic        w_s1_adv;
   logic [31:0] w_pack;

   assign w_s1_adv  = !r_s2_valid || out_ready;
   assign in_ready  = !r_s1_valid || w_s1_adv;
   assign out_valid = r_s2_valid;
   assign out_inst  = r_out_inst;
   assign out_err   = r_out_err;
   assign err_count = r_err_count;

   // A value fits an N-bit signed field when bits [31:N-1] are all sign copies.
   assign w_fits12 = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign w_fits13 = (&in_imm[31:12]) || !(|in_imm[31:12]);
   assign w_fits21 = (&in_imm[31:20]) || !(|in_imm[31:20]);

   always_comb begin
      w_fmt   = FMT_R;
      w_op_ok = 1'b1;
      case (in_opcode)
         7'b0000011, 7'b0010011, 7'b1100111: w_fmt = FMT_I;
         7'b0100011:                         w_fmt = FMT_S;
         7'b1100011:                         w_fmt = FMT_B;
         7'b0110111, 7'b0010111:             w_fmt = FMT_U;
         7'b1101111:                         w_fmt = FMT_J;
         7'b0110011:                         w_fmt = FMT_R;
         default:                            w_op_ok = 1'b0;
      endcase
      case (w_fmt)
         FMT_I, FMT_S: w_imm_ok = w_fits12;
         FMT_B:        w_imm_ok = w_fits13 && !in_imm[0];
         FMT_U:        w_imm_ok = (in_imm[11:0] == 12'd0);
         FMT_J:        w_imm_ok = w_fits21 && !in_imm[0];
         default:      w_imm_ok = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         r_s1_valid <= 1'b0;
      else if (in_ready)
         r_s1_valid <= in_valid;
      if (in_valid && in_ready) begin
         r_s1_fmt <= w_fmt;
         r_s1_err <= !w_op_ok || !w_imm_ok;
         r_s1_op  <= in_opcode;
         r_s1_rd  <= in_rd;
         r_s1_rs1 <= in_rs1;
         r_s1_rs2 <= in_rs2;
         r_s1_f3  <= in_funct3;
         r_s1_f7  <= in_funct7;
         r_s1_imm <= in_imm;
      end
   end

   always_comb begin
      case (r_s1_fmt)
         FMT_I:   w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
         FMT_S:   w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
         FMT_B:   w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                            r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
         FMT_U:   w_pack = {r_s1_imm[31:12], r_s1_rd, r_s1_op};
         FMT_J:   w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                            r_s1_rd, r_s1_op};
         default: w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      endcase
      if (r_s1_err)
         w_pack = NOP_INST;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid  <= 1'b0;
         r_out_inst  <= 32'd0;
         r_out_err   <= 1'b0;
         r_err_count <= '0;
      end else begin
         if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_out_inst <= w_pack;
               r_out_err  <= r_s1_err;
            end
         end
         // Counted when the rejected word leaves, so a dropped word is never counted.
         if (r_s2_valid && out_ready && r_out_err && !(&r_err_count))
            r_err_count <= r_err_count + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vectors with literal expectations plus a scoreboard model.
module tb_inst_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready, in_ready2;
   logic [6:0]  in_opcode;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [31:0] in_imm;
   logic        out_valid, out_valid2;
   logic        out_ready;
   logic [31:0] out_inst, out_inst2;
   logic        out_err, out_err2;
   logic [7:0]  err_count;
   logic [1:0]  err_count2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_encoder u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
      .out_err(out_err), .err_count(err_count)
   );

   inst_encoder #(.ERR_CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
      .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
      .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
      .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
      .out_err(out_err2), .err_count(err_count2)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference encoder: range rules use signed integer arithmetic, result is {err, word}.
   function automatic logic [32:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
                                             input logic [4:0] rs1, input logic [4:0] rs2,
                                             input logic [2:0] f3, input logic [6:0] f7,
                                             input logic [31:0] imm);
      int          v;
      bit          ok;
      logic [31:0] w;
      v  = imm;
      ok = 1'b1;
      w  = 32'd0;
      case (op)
         7'h03, 7'h13, 7'h67: begin
            ok = (v >= -2048) && (v <= 2047);
            w  = {imm[11:0], rs1, f3, rd, op};
         end
         7'h23: begin
            ok = (v >= -2048) && (v <= 2047);
            w  = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
         end
         7'h63: begin
            ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
            w  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
         end
         7'h37, 7'h17: begin
            ok = (v % 4096 == 0);
            w  = {imm[31:12], rd, op};
         end
         7'h6F: begin
            ok = (v >= -1048576) && (v <= 1048574) && (v % 2 == 0);
            w  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
         end
         7'h33:   w  = {f7, rs2, rs1, f3, rd, op};
         default: ok = 1'b0;
      endcase
      if (!ok) w = 32'h00000013;
      return {!ok, w};
   endfunction

   logic [32:0] exp_q[$];
   int          m_cnt = 0, m_cnt2 = 0, n_out = 0;
   bit          prev_stall = 0, stall_phase = 0, saw_in_ready_low = 0;
   logic [31:0] prev_inst;
   logic        prev_err;
   logic [32:0] e;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         m_cnt = 0;
         m_cnt2 = 0;
         prev_stall = 0;
      end else begin
         chk("err_count", 64'(err_count), 64'(m_cnt));
         chk("err_count_w2", 64'(err_count2), 64'(m_cnt2));
         if (prev_stall) begin
            chk("stall_hold", {31'd0, out_valid, out_err, out_inst}, {31'd0, 1'b1, prev_err, prev_inst});
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 64'(out_inst), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("sb_word", {31'd0, out_err, out_inst}, {31'd0, e});
               n_out++;
               if (e[32]) begin
                  if (m_cnt < 255) m_cnt++;
                  if (m_cnt2 < 3) m_cnt2++;
               end
            end
         end
         if (in_valid && in_ready)
            exp_q.push_back(model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
         if (stall_phase && !in_ready) saw_in_ready_low = 1;
         prev_stall = out_valid && !out_ready;
         prev_inst  = out_inst;
         prev_err   = out_err;
      end
   end

   // Presents a request and returns #1 after the edge that accepts it; in_valid stays high.
   task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] imm);
      int n = 0;
      in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
      in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid  = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         n++;
         if (n > 30) begin
            chk("accept_timeout", 64'd0, 64'd1);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic direct(input string name, input logic [6:0] op, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm,
                         input logic [31:0] exp_inst, input logic exp_err);
      send(op, rd, rs1, rs2, f3, f7, imm);
      in_valid = 1'b0;
      @(negedge clk);
      chk({name, "_lat1"}, 64'(out_valid), 64'd0);
      @(negedge clk);
      chk({name, "_vld"}, 64'(out_valid), 64'd1);
      chk({name, "_inst"}, 64'(out_inst), 64'(exp_inst));
      chk({name, "_err"}, 64'(out_err), 64'(exp_err));
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_opcode = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
      in_funct3 = '0; in_funct7 = '0; in_imm = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      direct("addi_m1", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
      direct("sw",      7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,        32'h0020A423, 1'b0);
      direct("beq_m4",  7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 32'hFE000EE3, 1'b0);
      direct("jal",     7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h001000EF, 1'b0);
      direct("lui",     7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
      direct("jalr_min",7'h67, 5'd1, 5'd5, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, 32'h800280E7, 1'b0);
      direct("jal_min", 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFF00000, 32'h8000006F, 1'b0);
      direct("rej_i",   7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,     32'h00000013, 1'b1);
      direct("rej_b",   7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,        32'h00000013, 1'b1);
      direct("rej_u",   7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1,        32'h00000013, 1'b1);
      direct("rej_op",  7'h7F, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1);
      @(negedge clk);
      chk("errcnt_after4", 64'(err_count), 64'd4);
      @(posedge clk); #1;
      direct("rej_op0", 7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,        32'h00000013, 1'b1);
      @(negedge clk);
      chk("errcnt_after5", 64'(err_count), 64'd5);
      chk("errcnt_w2_sat", 64'(err_count2), 64'd3);
      @(posedge clk); #1;

      base = n_out;
      out_ready = 1'b0;
      fork
         begin
            send(7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd7);
            send(7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
            send(7'h37, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000FFF);
            send(7'h23, 5'd0, 5'd7, 5'd8, 3'd1, 7'd0, 32'hFFFFF801);
            in_valid = 1'b0;
         end
         begin
            int n = 0;
            stall_phase = 1;
            while (!out_valid && n < 30) begin
               @(negedge clk);
               n++;
            end
            chk("bp_first_valid", 64'(out_valid), 64'd1);
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
            stall_phase = 0;
         end
      join
      repeat (12) @(negedge clk);
      chk("bp_delivered", 64'(n_out - base), 64'd4);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("bp_in_ready_low", 64'(saw_in_ready_low), 64'd1);
      @(posedge clk); #1;

      out_ready = 1'b0;
      send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(7'h7F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("rs_full_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_err_count", 64'(err_count), 64'd0);
      @(posedge clk); #1 out_ready = 1'b1;
      direct("post_rst_add", 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
Packs decoded instruction fields and a full 32-bit signed immediate into a 32-bit RV32I instruction word. Performs the inverse of the core's immediate extraction.
Used by the debug/self-test path to build instructions for injection into the fetch stream.
Two-stage valid/ready pipeline with immediate range/alignment checking and a saturating error counter.

Parameters:
ERR_CNT_W, 8, width of saturating error counter
NOP_INST, 32'h00000013, word emitted in place of any rejected instruction (addi x0,x0,0)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  encoder can accept request
in_opcode  input  7  major opcode (ISA_OPCODE_* values)
in_rd  input  5  destination register
in_rs1  input  5  source register 1
in_rs2  input  5  source register 2
in_funct3  input  3  funct3
in_funct7  input  7  funct7 (OP only)
in_imm  input  32  immediate as signed byte value (U-type: full value, low 12 bits zero)
out_valid  output  1  encoded word valid
out_ready  input  1  consumer accepts word
out_inst  output  32  encoded instruction
out_err  output  1  request rejected; out_inst = NOP_INST
err_count  output  ERR_CNT_W  number of rejected requests, saturating

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Ports are named clk and rst.
- Reset values: out_valid=0, out_inst=0, out_err=0, err_count=0, both stages empty.
- Reset asserted mid-operation drops in-flight requests; the next cycle after release has out_valid=0.
- Handshakes:
  - Input transfer on in_valid&&in_ready. Output transfer on out_valid&&out_ready.
  - in_ready = !s1_valid || s1_advance.
  - s1_advance = !s2_valid || out_ready.
  - in_ready is combinational from out_ready; no other combinational input-to-output paths.
- Pipeline:
  - Stage 1 registers the fields, the format, and the err decision.
  - Stage 2 registers the packed word; out_* are driven from stage 2.
  - Latency is 2 cycles from accept to out_valid. Throughput is 1/cycle while out_ready=1.
- Stall behaviour: while out_valid&&!out_ready, out_inst, out_err and out_valid hold stable and stage 2 does not advance.
- Format select by opcode:
  - I-type: LOAD, OP_IMMED, JALR.
  - S-type: STORE.
  - B-type: BRANCH.
  - U-type: LUI, AUIPC.
  - J-type: JAL.
  - R-type: OP (0110011).
  - Any other opcode is rejected.
- Range and alignment (imm treated as signed 32-bit):
  - I, S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - U: imm[11:0]=0, any upper value.
  - R: imm ignored, never an error.
- Packing:
  - I: {imm[11:0],rs1,f3,rd,op}.
  - S: {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
  - B: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}.
  - U: {imm[31:12],rd,op}.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
  - R: {f7,rs2,rs1,f3,rd,op}.
  - Unused fields for a format are ignored.
- Error handling:
  - On rejection: out_inst=NOP_INST, out_err=1.
  - err_count increments once per rejected word, at its output transfer. It saturates at all-ones.
  - out_err=0 for all accepted words.
- Simultaneous stage-2 output transfer and stage-1 advance in the same cycle is a normal pipelined move with no bubble.

Test Plan:
- OP_IMMED rd=1 rs1=0 f3=0 imm=0xFFFFFFFF -> out_inst=0xFFF00093, out_err=0, out_valid 2 cycles after accept.
- STORE rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423. BRANCH rs1=rs2=0 f3=0 imm=-4 -> 0xFE000EE3.
- JAL rd=1 imm=0x800 -> 0x001000EF. LUI rd=5 imm=0x12345000 -> 0x123452B7.
- Rejection cases, each -> 0x00000013 with out_err=1:
  - OP_IMMED imm=2048.
  - BRANCH imm=3.
  - LUI imm=0x00000001.
  - opcode 7'b1111111.
  - After the four, err_count=4. With ERR_CNT_W=2, 5 errors -> err_count=3.
- Backpressure:
  - Stream 4 back-to-back requests; hold out_ready=0 for 3 cycles after the first out_valid.
  - Required: out_inst stable during the stall; in_ready=0 once both stages are full.
  - All 4 words are delivered in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with both stages full -> out_valid=0 and err_count=0 the following cycle; the next request encodes correctly.
